mcs8_fetch_unit: RTL and testbench
==================================

# mcs8_fetch_unit

Instruction fetch unit with an 8-level program-counter stack for the MCS8 pipelined core. It sits directly upstream of the F1→F2 fetch pipe: it drives the instruction ROM address and registers the returned byte into the F1 stage (IR, valid, PC). It applies control-flow redirects (JMP/CALL/RET) from the execute stage and emits a flush pulse for the downstream fetch/decode registers.

## Interface
Parameters:
- AW, 14, instruction address width
- DW, 8, instruction byte width
- DEPTH_LOG2, 3, log2 of the stack depth (8 levels)

Ports:
- CLK_I  in  1  clock, all state updates on rising edge
- nRST_I  in  1  reset; one clock; reset is asynchronous and active-low
- I_DAT_I  in  DW  ROM read data; combinational response to I_ADDR_O in the same cycle
- I_ADDR_O  out  AW  current PC, i.e. stack[ndx]; driven combinationally from registers
- STALL_I  in  1  hold fetch; no PC advance, F1 outputs held
- REDIR_I  in  1  single-cycle control-flow redirect request
- REDIR_OP_I  in  2  00 JMP, 01 CALL, 10 RET, 11 treated as JMP
- REDIR_ADDR_I  in  AW  jump/call target; ignored for RET
- REDIR_LINK_I  in  AW  return address for CALL (address after the 3-byte CALL); ignored otherwise
- F1_IR_O  out  DW  fetched byte
- F1_VALID_O  out  1  F1_IR_O holds a live byte
- F1_PC_O  out  AW  address the F1 byte was fetched from
- FLUSH_O  out  1  one-cycle pulse: downstream F2/F3/D must invalidate their contents
- STK_DEPTH_O  out  DEPTH_LOG2  current stack index ndx
- STK_ERR_O  out  1  sticky: set on push at ndx=7 or pop at ndx=0; cleared only by reset

## Operation
- State: stack[0..7] (AW each), ndx (3 bits), F1 registers, FLUSH, STK_ERR.
- Reset (asynchronous assert, synchronous-to-clock release is the integrator's job): all stack entries 0, ndx 0, F1_IR_O 0, F1_VALID_O 0, F1_PC_O 0, FLUSH_O 0, STK_ERR_O 0. I_ADDR_O = 0 during and after reset.
- Per-edge priority: REDIR_I > STALL_I > normal fetch.
- Normal (REDIR_I=0, STALL_I=0): F1_IR_O←I_DAT_I, F1_PC_O←stack[ndx], F1_VALID_O←1, stack[ndx]←stack[ndx]+1 modulo 2^AW (3FFF→0000). FLUSH_O←0.
- Stall (REDIR_I=0, STALL_I=1): PC, ndx, F1_* unchanged; FLUSH_O←0.
- Redirect (REDIR_I=1, STALL_I ignored): F1_VALID_O←0, F1_IR_O and F1_PC_O hold, FLUSH_O←1.
  - JMP: stack[ndx]←REDIR_ADDR_I.
  - CALL: stack[ndx]←REDIR_LINK_I; stack[ndx+1]←REDIR_ADDR_I; ndx←ndx+1 (mod 8). At ndx=7: wraps to 0, overwrites stack[0], sets STK_ERR_O.
  - RET: ndx←ndx−1 (mod 8); fetch resumes from the stored link. At ndx=0: wraps to 7, sets STK_ERR_O.
- Stack wrap mirrors 8008 semantics: no blocking, silent overwrite apart from the flag.
- Link values are supplied by execute, never derived from the fetch PC, because fetch runs ahead of execute.

## Timing
- Fetch latency: ROM address in cycle n → byte on F1_IR_O with F1_VALID_O=1 in cycle n+1.
- Throughput: one byte per cycle when neither stalled nor redirected.
- First valid byte after reset release: F1_VALID_O=1 with F1_PC_O=0 after the first rising edge.
- Redirect asserted in cycle n: I_ADDR_O = new PC and FLUSH_O=1, F1_VALID_O=0 in n+1. Target byte valid in n+2 with F1_PC_O = target. FLUSH_O drops in n+2 unless redirected again.
- Back-to-back redirects: each is applied in order. The second one's target wins. FLUSH_O stays high and F1_VALID_O stays 0.
- STALL_I releasing after k cycles: the held byte is presented for k+1 cycles total. The next byte follows the cycle after release.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then free-run with ROM[a]=a[7:0]: F1_PC_O 0,1,2,… on consecutive cycles, F1_IR_O matches, F1_VALID_O=1 from first edge.
- JMP to 0x1234 while PC=0x0010: next cycle FLUSH_O=1, F1_VALID_O=0, I_ADDR_O=0x1234. Following cycle F1_PC_O=0x1234, F1_VALID_O=1.
- CALL target 0x0200 link 0x0013 at ndx=0, then later RET: STK_DEPTH_O 0→1→0. After RET, fetch resumes at 0x0013.
- Eight nested CALLs from ndx=0: the eighth wraps STK_DEPTH_O to 0 and sets STK_ERR_O. A RET at ndx=0 also sets it. STK_ERR_O remains set until nRST_I.
- PC at 0x3FFF, free-run: next F1_PC_O=0x3FFF, then 0x0000. STALL_I high 3 cycles holds F1_PC_O and I_ADDR_O. A REDIR_I concurrent with STALL_I still redirects.
- Assert nRST_I low asynchronously mid-run at PC=0x0055, ndx=2: outputs go to reset values before the next edge. After release, fetch restarts at 0x0000.

Source files
------------

// File: rtl/mcs8_fetch_unit.sv
// MCS8 instruction fetch unit.
// Holds an 8-level program-counter stack whose top entry is the live fetch PC.
// Drives the ROM address, registers the returned byte into the F1 stage, and
// applies JMP/CALL/RET redirects from execute with a one-cycle flush pulse.
module mcs8_fetch_unit #(
    parameter int AW         = 14,
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK_I,
    input  logic                  nRST_I,
    input  logic [DW-1:0]         I_DAT_I,
    output logic [AW-1:0]         I_ADDR_O,
    input  logic                  STALL_I,
    input  logic                  REDIR_I,
    input  logic [1:0]            REDIR_OP_I,
    input  logic [AW-1:0]         REDIR_ADDR_I,
    input  logic [AW-1:0]         REDIR_LINK_I,
    output logic [DW-1:0]         F1_IR_O,
    output logic                  F1_VALID_O,
    output logic [AW-1:0]         F1_PC_O,
    output logic                  FLUSH_O,
    output logic [DEPTH_LOG2-1:0] STK_DEPTH_O,
    output logic                  STK_ERR_O
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;

    logic [AW-1:0]         pcStack [DEPTH];
    logic [DEPTH_LOG2-1:0] ndx;
    logic [DEPTH_LOG2-1:0] ndxUp;
    logic [DEPTH_LOG2-1:0] ndxDown;
    logic [AW-1:0]         curPc;
    logic [DW-1:0]         f1Ir;
    logic                  f1Valid;
    logic [AW-1:0]         f1Pc;
    logic                  flush;
    logic                  stkErr;

    // Stack index neighbours; both wrap silently like the 8008 stack.
    assign ndxUp   = ndx + 1'b1;
    assign ndxDown = ndx - 1'b1;
    assign curPc   = pcStack[ndx];

    // Stack, index, F1 stage and flags; redirect beats stall beats fetch.
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcStack[i] <= '0;
            end
            ndx     <= '0;
            f1Ir    <= '0;
            f1Valid <= 1'b0;
            f1Pc    <= '0;
            flush   <= 1'b0;
            stkErr  <= 1'b0;
        end else if (REDIR_I) begin
            f1Valid <= 1'b0;
            flush   <= 1'b1;
            case (REDIR_OP_I)
                OP_CALL: begin
                    // Link comes from execute: fetch has already run past the CALL.
                    pcStack[ndx]   <= REDIR_LINK_I;
                    pcStack[ndxUp] <= REDIR_ADDR_I;
                    ndx            <= ndxUp;
                    if (&ndx) begin
                        stkErr <= 1'b1;
                    end
                end
                OP_RET: begin
                    ndx <= ndxDown;
                    if (ndx == '0) begin
                        stkErr <= 1'b1;
                    end
                end
                default: begin
                    pcStack[ndx] <= REDIR_ADDR_I;
                end
            endcase
        end else if (STALL_I) begin
            flush <= 1'b0;
        end else begin
            f1Ir         <= I_DAT_I;
            f1Pc         <= curPc;
            f1Valid      <= 1'b1;
            pcStack[ndx] <= curPc + 1'b1;
            flush        <= 1'b0;
        end
    end

    assign I_ADDR_O    = curPc;
    assign F1_IR_O     = f1Ir;
    assign F1_VALID_O  = f1Valid;
    assign F1_PC_O     = f1Pc;
    assign FLUSH_O     = flush;
    assign STK_DEPTH_O = ndx;
    assign STK_ERR_O   = stkErr;

endmodule

// File: tb/tb_mcs8_fetch_unit.sv
// Self-checking bench for mcs8_fetch_unit: directed scenarios plus random
// redirect/stall traffic, compared against a cycle-level reference model.
module tb_mcs8_fetch_unit;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int DL = 3;
    localparam int ASPACE = 1 << AW;

    logic          CLK_I = 1'b0;
    logic          nRST_I = 1'b0;
    logic [DW-1:0] I_DAT_I;
    logic [AW-1:0] I_ADDR_O;
    logic          STALL_I = 1'b0;
    logic          REDIR_I = 1'b0;
    logic [1:0]    REDIR_OP_I = 2'b00;
    logic [AW-1:0] REDIR_ADDR_I = '0;
    logic [AW-1:0] REDIR_LINK_I = '0;
    logic [DW-1:0] F1_IR_O;
    logic          F1_VALID_O;
    logic [AW-1:0] F1_PC_O;
    logic          FLUSH_O;
    logic [DL-1:0] STK_DEPTH_O;
    logic          STK_ERR_O;

    logic [DW-1:0] romData [ASPACE];

    int nCompared = 0;
    int nMismatched = 0;

    // reference model state
    int mStk [8];
    int mNdx;
    int mIr;
    int mValid;
    int mPc;
    int mFlush;
    int mErr;

    mcs8_fetch_unit #(.AW(AW), .DW(DW), .DEPTH_LOG2(DL)) dut (
        .CLK_I        (CLK_I),
        .nRST_I       (nRST_I),
        .I_DAT_I      (I_DAT_I),
        .I_ADDR_O     (I_ADDR_O),
        .STALL_I      (STALL_I),
        .REDIR_I      (REDIR_I),
        .REDIR_OP_I   (REDIR_OP_I),
        .REDIR_ADDR_I (REDIR_ADDR_I),
        .REDIR_LINK_I (REDIR_LINK_I),
        .F1_IR_O      (F1_IR_O),
        .F1_VALID_O   (F1_VALID_O),
        .F1_PC_O      (F1_PC_O),
        .FLUSH_O      (FLUSH_O),
        .STK_DEPTH_O  (STK_DEPTH_O),
        .STK_ERR_O    (STK_ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    // combinational ROM
    assign I_DAT_I = romData[I_ADDR_O];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string where);
        chk({where, ":I_ADDR_O"},    32'(I_ADDR_O),    32'(mStk[mNdx]));
        chk({where, ":F1_IR_O"},     32'(F1_IR_O),     32'(mIr));
        chk({where, ":F1_VALID_O"},  32'(F1_VALID_O),  32'(mValid));
        chk({where, ":F1_PC_O"},     32'(F1_PC_O),     32'(mPc));
        chk({where, ":FLUSH_O"},     32'(FLUSH_O),     32'(mFlush));
        chk({where, ":STK_DEPTH_O"}, 32'(STK_DEPTH_O), 32'(mNdx));
        chk({where, ":STK_ERR_O"},   32'(STK_ERR_O),   32'(mErr));
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mStk[i] = 0;
        mNdx = 0; mIr = 0; mValid = 0; mPc = 0; mFlush = 0; mErr = 0;
    endtask

    // Model of one rising edge, written from the behavioural rules.
    task automatic modelEdge(input bit redir, input int op, input int addr, input int link, input bit stall);
        if (redir) begin
            mValid = 0;
            mFlush = 1;
            if (op == 1) begin
                mStk[mNdx] = link;
                mStk[(mNdx + 1) % 8] = addr;
                if (mNdx == 7) mErr = 1;
                mNdx = (mNdx + 1) % 8;
            end else if (op == 2) begin
                if (mNdx == 0) mErr = 1;
                mNdx = (mNdx + 7) % 8;
            end else begin
                mStk[mNdx] = addr;
            end
        end else if (stall) begin
            mFlush = 0;
        end else begin
            mIr = int'(romData[mStk[mNdx]]);
            mPc = mStk[mNdx];
            mValid = 1;
            mStk[mNdx] = (mStk[mNdx] + 1) % ASPACE;
            mFlush = 0;
        end
    endtask

    // Drive inputs, clock once, then check at the falling edge.
    task automatic step(input string where, input bit redir, input int op, input int addr,
                        input int link, input bit stall);
        REDIR_I = redir;
        REDIR_OP_I = 2'(op);
        REDIR_ADDR_I = AW'(addr);
        REDIR_LINK_I = AW'(link);
        STALL_I = stall;
        @(posedge CLK_I);
        modelEdge(redir, op, addr, link, stall);
        @(negedge CLK_I);
        checkAll(where);
    endtask

    task automatic run(input string where, input int n);
        for (int i = 0; i < n; i++) step(where, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic doReset();
        nRST_I = 1'b0;
        modelReset();
        #1;
        checkAll("rst_async");
        @(negedge CLK_I);
        checkAll("rst_held");
        nRST_I = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < ASPACE; i++) romData[i] = 8'($urandom);
        modelReset();

        // reset and free run from 0
        #1;
        checkAll("rst_init");
        @(negedge CLK_I);
        @(negedge CLK_I);
        checkAll("rst_init_held");
        nRST_I = 1'b1;
        run("freerun", 16);

        // JMP at PC 0x0010
        step("jmp", 1'b1, 0, 'h1234, 0, 1'b0);
        run("jmp_tgt", 3);

        // CALL / RET pair
        step("call", 1'b1, 1, 'h0200, 'h0013, 1'b0);
        run("callee", 4);
        step("ret", 1'b1, 2, 0, 0, 1'b0);
        run("after_ret", 3);

        // back-to-back redirects: second target wins
        step("b2b_a", 1'b1, 0, 'h0100, 0, 1'b0);
        step("b2b_b", 1'b1, 3, 'h0300, 0, 1'b0);
        run("b2b_tgt", 2);

        // PC wrap at top of address space
        step("jmp_top", 1'b1, 0, 'h3FFE, 0, 1'b0);
        run("wrap", 4);

        // stall for three cycles, then release
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 0, 0, 0, 1'b1);
        run("unstall", 2);

        // redirect concurrent with stall still redirects
        step("redir_stall", 1'b1, 0, 'h0777, 0, 1'b1);
        step("stall_after", 1'b0, 0, 0, 0, 1'b1);
        run("post_rs", 2);

        // eight nested CALLs wrap the stack and set the error flag
        for (int i = 0; i < 8; i++) begin
            step("ncall", 1'b1, 1, 'h0400 + i * 16, 'h0040 + i, 1'b0);
            run("ncall_run", 1);
        end
        // RET at index 0 underflows
        step("uflow", 1'b1, 2, 0, 0, 1'b0);
        run("uflow_run", 2);

        // random traffic; error flag stays sticky
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit s;
            r = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            step("rand", r, int'($urandom_range(0, 3)), int'($urandom_range(0, ASPACE - 1)),
                 int'($urandom_range(0, ASPACE - 1)), s);
        end

        // clean reset clears the sticky error
        @(negedge CLK_I);
        doReset();
        run("rst2_run", 2);

        // build PC=0x0055 at ndx=2, then reset asynchronously mid-cycle
        step("c1", 1'b1, 1, 'h0030, 'h0002, 1'b0);
        step("c2", 1'b1, 1, 'h0050, 'h0031, 1'b0);
        run("to55", 5);
        chk("pre_async_pc", 32'(I_ADDR_O), 32'h0055);
        chk("pre_async_ndx", 32'(STK_DEPTH_O), 32'd2);
        #2;
        nRST_I = 1'b0;
        modelReset();
        #1;
        checkAll("async_mid");
        @(negedge CLK_I);
        nRST_I = 1'b1;
        run("restart", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        nMismatched++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $fatal(1, "timeout");
    end

endmodule
